cfa_cross_window: RTL and testbench
===================================

CFA_CROSS_WINDOW -- requirements
Module: cfa_cross_window

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DW, 12, pixel width
- IMG_W, 4, frame width in pixels (>=2)
- IMG_H, 3, frame height in lines (>=2)
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge
- rst, in, 1, asynchronous active-low reset
- sof_in, in, 1, marks first pixel of a frame; sampled with pix_in
- pix_in, in, DW, raw Bayer pixel, raster order
- pix_valid, in, 1, pix_in valid
- pix_ready, out, 1, block can accept; accept = pix_valid & pix_ready
- win_valid, out, 1, window outputs valid this cycle
- c_out, out, DW, centre pixel
- v_m1, out, DW, pixel above the centre
- h_m1, out, DW, pixel left of the centre
- h_p1, out, DW, pixel right of the centre
- v_p1, out, DW, pixel below the centre
- row_odd, out, 1, centre row parity
- col_odd, out, 1, centre column parity
- eof_out, out, 1, last window of the frame

Function
REQ-003 Block SHALL buffer two full lines internally and emit one cross window (centre plus 4 neighbours) per centre pixel, in raster order; all outputs registered.
REQ-004 FSM SHALL have states IDLE, FILL, RUN, FLUSH.
- IDLE: pix_ready=1; accepted pixel with sof_in=1 stored as (0,0), go to FILL; accepted pixel without sof_in dropped.
- FILL: accept row 0; no windows; after (0,IMG_W-1), go to RUN.
- RUN: accept rows 1..IMG_H-1; after (IMG_H-1,IMG_W-1), go to FLUSH.
- FLUSH: pix_ready=0; emit last row; return to IDLE.
REQ-005 For r<IMG_H-1, window (r,c) SHALL be presented with win_valid=1 in the cycle after pixel (r+1,c) is accepted.
REQ-006 Windows (IMG_H-1,0..IMG_W-1) SHALL be presented on the IMG_W consecutive cycles after window (IMG_H-2,IMG_W-1).
REQ-007 pix_ready SHALL be 0 from the cycle after pixel (IMG_H-1,IMG_W-1) is accepted until eof_out=1 inclusive, and 1 the cycle after.
REQ-008 Edges SHALL mirror by distance 1 to preserve CFA phase:
- row 0: v_m1=v_p1
- row IMG_H-1: v_p1=v_m1
- col 0: h_m1=h_p1
- col IMG_W-1: h_p1=h_m1
REQ-009 Cycles with no accept SHALL advance no counters and produce no window (RUN/FILL); gaps are unlimited.
REQ-010 Accepted sof_in=1 in FILL or RUN SHALL abandon the current frame: no further windows from it, no eof_out, pixel stored as (0,0), state FILL.
REQ-011 Output side has no backpressure; downstream always accepts.
REQ-012 row_odd/col_odd SHALL equal bit 0 of the centre row/column; eof_out=1 only with window (IMG_H-1,IMG_W-1).
REQ-013 Outputs SHALL hold their last value when win_valid=0.

Reset
REQ-014 rst=0 SHALL immediately force state IDLE, counters 0, win_valid=0, eof_out=0, all data/parity outputs 0, pix_ready=1; line buffer contents need no reset.
REQ-015 Reset mid-frame SHALL discard the frame; the first post-reset window requires a new sof_in.

Verification (IMG_W=4, IMG_H=3, pixel (r,c)=16r+c)
REQ-016 Assert rst=0 mid-RUN -> same cycle win_valid=0, outputs 0, pix_ready=1.
REQ-017 Stream full frame without gaps -> exactly 12 windows, raster order. Window (1,1) = c 17, v_m1 1, h_m1 16, h_p1 18, v_p1 33, row_odd 1, col_odd 1.
REQ-018 Corners:
- (0,0) -> c 0, v_m1 16, v_p1 16, h_m1 1, h_p1 1.
- (2,3) -> c 35, v_m1 19, v_p1 19, h_m1 34, h_p1 34, eof_out 1.
REQ-019 Hold pix_valid=1 with the next frame's sof pixel through FLUSH -> pix_ready=0 for the 4 flush windows plus the preceding cycle, pixel not consumed; accepted the cycle after eof_out, next frame correct.
REQ-020 Assert sof_in at pixel (1,2) of frame 1 -> no further frame-1 windows, no eof_out; new frame yields all 12 correct windows.
REQ-021 Randomly drop pix_valid (50%) -> identical window sequence to REQ-017; each window exactly one cycle after its trigger accept.

Source files
------------

// File: rtl/cfa_cross_window.sv
// Bayer cross-window generator: buffers two lines and emits centre + 4 neighbours per pixel,
// mirroring edges by distance 1 so the CFA phase of every neighbour matches the centre.
module cfa_cross_window #(
  parameter int DW    = 12,
  parameter int IMG_W = 4,
  parameter int IMG_H = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sof_in,
  input  logic [DW-1:0] pix_in,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic          win_valid,
  output logic [DW-1:0] c_out,
  output logic [DW-1:0] v_m1,
  output logic [DW-1:0] h_m1,
  output logic [DW-1:0] h_p1,
  output logic [DW-1:0] v_p1,
  output logic          row_odd,
  output logic          col_odd,
  output logic          eof_out
);

  localparam int CIW = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int FW  = $clog2(IMG_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic           LAST_B   = 1'((IMG_H - 1) % 2);
  localparam logic [CIW-1:0] COL_LAST = CIW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - 1);

  typedef struct packed {
    logic [DW-1:0] c;
    logic [DW-1:0] vm;
    logic [DW-1:0] hm;
    logic [DW-1:0] hp;
    logic [DW-1:0] vp;
    logic          ro;
    logic          co;
  } win_t;

  // Line buffer bank is selected by row parity; no reset needed.
  logic [DW-1:0] lb [2][IMG_W];

  logic [1:0]     state_q, state_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CIW-1:0] col_q, col_d;
  logic [FW-1:0]  fc_q, fc_d;
  logic           vld_q, eof_q;
  win_t           win_q, win_d;

  logic           acc, emit, wr_en, wr_b, cb, ab, eof_d;
  logic [CIW-1:0] wr_c, wc, cm1, cp1;
  logic [RW-1:0]  wrow;
  logic [DW-1:0]  above;

  assign pix_ready = (state_q != S_FLUSH);
  assign acc       = pix_valid & pix_ready;

  // In RUN the window row is one behind the incoming row; the bank of row r-1 is read
  // before the incoming pixel of row r+1 overwrites the same slot.
  always_comb begin
    if (state_q == S_FLUSH) begin
      cb   = LAST_B;
      ab   = ~LAST_B;
      wc   = (fc_q < FW'(IMG_W)) ? fc_q[CIW-1:0] : '0;
      wrow = ROW_LAST;
    end else begin
      cb   = ~row_q[0];
      ab   = row_q[0];
      wc   = col_q;
      wrow = row_q - RW'(1);
    end
    cm1      = (wc == '0)       ? CIW'(1)         : wc - CIW'(1);
    cp1      = (wc == COL_LAST) ? CIW'(IMG_W - 2) : wc + CIW'(1);
    above    = lb[ab][wc];
    win_d.c  = lb[cb][wc];
    win_d.hm = lb[cb][cm1];
    win_d.hp = lb[cb][cp1];
    if (state_q == S_FLUSH) begin
      win_d.vm = above;
      win_d.vp = above;
    end else begin
      win_d.vp = pix_in;
      win_d.vm = (wrow == '0) ? pix_in : above;
    end
    win_d.ro = wrow[0];
    win_d.co = wc[0];
    eof_d    = (state_q == S_FLUSH) && (wc == COL_LAST);
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    fc_d    = fc_q;
    emit    = 1'b0;
    wr_en   = 1'b0;
    wr_b    = row_q[0];
    wr_c    = col_q;
    case (state_q)
      S_IDLE: begin
        if (acc && sof_in) begin
          wr_en   = 1'b1;
          wr_b    = 1'b0;
          wr_c    = '0;
          row_d   = '0;
          col_d   = CIW'(1);
          state_d = S_FILL;
        end
      end
      S_FILL, S_RUN: begin
        if (acc && sof_in) begin
          wr_en   = 1'b1;
          wr_b    = 1'b0;
          wr_c    = '0;
          row_d   = '0;
          col_d   = CIW'(1);
          state_d = S_FILL;
        end else if (acc) begin
          wr_en = 1'b1;
          emit  = (state_q == S_RUN);
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (state_q == S_FILL) begin
              row_d   = RW'(1);
              state_d = S_RUN;
            end else if (row_q == ROW_LAST) begin
              fc_d    = '0;
              state_d = S_FLUSH;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CIW'(1);
          end
        end
      end
      S_FLUSH: begin
        // Extra cycle at fc==IMG_W keeps pix_ready low while eof_out is shown.
        if (fc_q < FW'(IMG_W)) begin
          emit = 1'b1;
          fc_d = fc_q + FW'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      fc_q    <= '0;
      vld_q   <= 1'b0;
      eof_q   <= 1'b0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      fc_q    <= fc_d;
      vld_q   <= emit;
      eof_q   <= emit & eof_d;
      if (emit) win_q <= win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) lb[wr_b][wr_c] <= pix_in;
  end

  assign win_valid = vld_q;
  assign c_out     = win_q.c;
  assign v_m1      = win_q.vm;
  assign h_m1      = win_q.hm;
  assign h_p1      = win_q.hp;
  assign v_p1      = win_q.vp;
  assign row_odd   = win_q.ro;
  assign col_odd   = win_q.co;
  assign eof_out   = eof_q;

endmodule

// File: tb/tb_cfa_cross_window.sv
// Scoreboard bench for cfa_cross_window: frame-array reference model with mirrored
// neighbour lookup, expected windows queued with their due time, monitor pops on win_valid.
module tb_cfa_cross_window;
  localparam int DW = 12, W = 4, H = 3, P = 10;

  logic          clk = 1'b0, rst = 1'b0, sof_in = 1'b0, pix_valid = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic          pix_ready, win_valid, row_odd, col_odd, eof_out;
  logic [DW-1:0] c_out, v_m1, h_m1, h_p1, v_p1;

  cfa_cross_window #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .sof_in(sof_in), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .win_valid(win_valid), .c_out(c_out), .v_m1(v_m1),
    .h_m1(h_m1), .h_p1(h_p1), .v_p1(v_p1), .row_odd(row_odd), .col_odd(col_odd),
    .eof_out(eof_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r; int c;
    logic [DW-1:0] cv, vm, hm, hp, vp;
    bit ro, co, eof;
    longint t;
  } win_t;

  win_t          exq[$];
  win_t          cap[H][W];
  bit            capv[H][W];
  logic [DW-1:0] img[H][W];
  int            idx = 0;
  bit            in_frame = 0, flush_act = 0;
  longint        flush_t = 0;
  int            n_chk = 0, n_fail = 0;

  function automatic void chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic int refl(int i, int n);
    if (i < 0) return -i;
    if (i >= n) return 2 * n - 2 - i;
    return i;
  endfunction

  function automatic void push_win(int r, int c, longint t);
    win_t w;
    w.r = r; w.c = c; w.t = t;
    w.cv = img[r][c];
    w.vm = img[refl(r - 1, H)][c];
    w.vp = img[refl(r + 1, H)][c];
    w.hm = img[r][refl(c - 1, W)];
    w.hp = img[r][refl(c + 1, W)];
    w.ro = r[0]; w.co = c[0];
    w.eof = (r == H - 1) && (c == W - 1);
    exq.push_back(w);
  endfunction

  // A window is due one cycle after the accept of the pixel below it; the last row follows the frame end.
  function automatic void model_accept(logic [DW-1:0] p, bit sof, longint t);
    int r, c;
    if (sof) begin in_frame = 1; idx = 0; end
    if (!in_frame) return;
    r = idx / W; c = idx % W;
    img[r][c] = p;
    idx++;
    if (r >= 1) push_win(r - 1, c, t + 5);
    if (idx == W * H) begin
      for (int k = 0; k < W; k++) push_win(H - 1, k, t + P * (k + 1) + 5);
      in_frame = 0; flush_act = 1; flush_t = t;
    end
  endfunction

  function automatic void model_reset();
    exq.delete();
    in_frame = 0; flush_act = 0; idx = 0;
  endfunction

  always @(negedge clk) begin
    win_t e;
    bit exp_rdy;
    exp_rdy = !(flush_act && ($time > flush_t) && ($time < flush_t + P * (W + 1)));
    chk("pix_ready", pix_ready, exp_rdy);
    if (win_valid) begin
      if (exq.size() == 0) chk("unexpected_window", 1, 0);
      else begin
        e = exq.pop_front();
        n_chk++;
        if ({c_out, v_m1, h_m1, h_p1, v_p1, row_odd, col_odd, eof_out} !==
            {e.cv, e.vm, e.hm, e.hp, e.vp, e.ro, e.co, e.eof} || $time != e.t) begin
          n_fail++;
          $display("FAIL window(%0d,%0d): got t=%0d c=%0d vm=%0d hm=%0d hp=%0d vp=%0d ro=%0d co=%0d eof=%0d expected t=%0d c=%0d vm=%0d hm=%0d hp=%0d vp=%0d ro=%0d co=%0d eof=%0d",
                   e.r, e.c, $time, c_out, v_m1, h_m1, h_p1, v_p1, row_odd, col_odd, eof_out,
                   e.t, e.cv, e.vm, e.hm, e.hp, e.vp, e.ro, e.co, e.eof);
        end
        cap[e.r][e.c].cv = c_out; cap[e.r][e.c].vm = v_m1; cap[e.r][e.c].hm = h_m1;
        cap[e.r][e.c].hp = h_p1;  cap[e.r][e.c].vp = v_p1;  cap[e.r][e.c].ro = row_odd;
        cap[e.r][e.c].co = col_odd; cap[e.r][e.c].eof = eof_out;
        capv[e.r][e.c] = 1;
      end
    end else begin
      chk("eof_without_window", eof_out, 0);
      if (exq.size() > 0 && exq[0].t < $time) begin
        e = exq.pop_front();
        n_chk++; n_fail++;
        $display("FAIL missing_window(%0d,%0d): got none expected at t=%0d", e.r, e.c, e.t);
      end
    end
  end

  task automatic send(input logic [DW-1:0] p, input bit sof, input int gap, output longint t_acc);
    bit ok = 0, acc;
    t_acc = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk); #1;
      pix_in = p; sof_in = sof;
      pix_valid = ($urandom_range(99) >= gap);
      acc = pix_valid && pix_ready;
      @(posedge clk);
      if (acc) begin
        t_acc = $time; ok = 1;
        model_accept(p, sof, t_acc);
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input bit rnd, input int gap, input int from, input int to, output longint tl);
    logic [DW-1:0] p;
    tl = 0;
    for (int i = from; i < to; i++) begin
      p = rnd ? DW'($urandom_range(4095)) : DW'(16 * (i / W) + (i % W));
      send(p, i == 0, gap, tl);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; pix_valid = 0; sof_in = 0; end
  endtask

  initial begin
    longint t, tl;
    #3;
    chk("rst_win_valid", win_valid, 0);
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_eof", eof_out, 0);
    chk("rst_data", {c_out, v_m1, h_m1, h_p1, v_p1, row_odd, col_odd}, 0);
    @(negedge clk); #1; rst = 1;

    // pixels without sof in IDLE produce nothing
    for (int i = 0; i < 3; i++) send(DW'(i + 5), 0, 0, t);
    idle(2);

    // gapless ramp frame, then the documented window values
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) capv[r][c] = 0;
    send_frame(0, 0, 0, W * H, tl);
    idle(8);
    chk("w11_seen", capv[1][1], 1);
    chk("w11_c", cap[1][1].cv, 17);  chk("w11_vm", cap[1][1].vm, 1);
    chk("w11_hm", cap[1][1].hm, 16); chk("w11_hp", cap[1][1].hp, 18);
    chk("w11_vp", cap[1][1].vp, 33); chk("w11_ro", cap[1][1].ro, 1);
    chk("w11_co", cap[1][1].co, 1);
    chk("w00_seen", capv[0][0], 1);
    chk("w00_c", cap[0][0].cv, 0);   chk("w00_vm", cap[0][0].vm, 16);
    chk("w00_vp", cap[0][0].vp, 16); chk("w00_hm", cap[0][0].hm, 1);
    chk("w00_hp", cap[0][0].hp, 1);
    chk("w23_seen", capv[2][3], 1);
    chk("w23_c", cap[2][3].cv, 35);  chk("w23_vm", cap[2][3].vm, 19);
    chk("w23_vp", cap[2][3].vp, 19); chk("w23_hm", cap[2][3].hm, 34);
    chk("w23_hp", cap[2][3].hp, 34); chk("w23_eof", cap[2][3].eof, 1);

    // next frame's sof held through FLUSH, accepted the cycle after eof_out
    send_frame(0, 0, 0, W * H, tl);
    send(DW'($urandom_range(4095)), 1, 0, t);
    chk("sof_after_flush_delay", t - tl, P * (W + 2));
    send_frame(1, 0, 1, W * H, tl);
    idle(8);

    // sof at (1,2) abandons the frame
    send_frame(0, 0, 0, W + 2, tl);
    send_frame(1, 0, 0, W * H, tl);
    idle(8);

    // 50% random input gaps
    repeat (4) begin
      send_frame(1, 50, 0, W * H, tl);
      idle($urandom_range(3));
    end
    idle(8);

    // asynchronous reset mid-RUN
    send_frame(0, 0, 0, W + 3, tl);
    #2;
    chk("pre_reset_win_valid", win_valid, 1);
    rst = 0;
    model_reset();
    #1;
    chk("mid_rst_win_valid", win_valid, 0);
    chk("mid_rst_pix_ready", pix_ready, 1);
    chk("mid_rst_eof", eof_out, 0);
    chk("mid_rst_data", {c_out, v_m1, h_m1, h_p1, v_p1, row_odd, col_odd}, 0);
    repeat (2) @(negedge clk);
    #1; rst = 1;

    // remainder of the discarded frame is dropped, then a fresh frame
    send_frame(0, 0, W + 3, W * H, tl);
    send_frame(1, 50, 0, W * H, tl);
    idle(10);
    chk("queue_empty", exq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
